// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, clock-channel pattern, aligner state
// and the token decoder used by the transmit and receive paths.
package tmds_pkg;

  // Control tokens, one per {c1,c0} value.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Word sent on the TMDS clock channel every pixel clock.
  localparam logic [9:0] CLK_PATTERN = 10'b1111100000;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } aligner_state_e;

  // Returns {is_ctrl, c1, c0}; {c1, c0} is zero for non-token words.
  function automatic logic [2:0] token_decode(input logic [9:0] word);
    logic [2:0] res;
    case (word)
      CTRL_TOKEN_00: res = 3'b100;
      CTRL_TOKEN_01: res = 3'b101;
      CTRL_TOKEN_10: res = 3'b110;
      CTRL_TOKEN_11: res = 3'b111;
      default:       res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Per-channel TMDS word aligner: slides a 10-bit window over two consecutive
// deserializer words until control tokens repeat at one offset, then holds it.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_CYCLES = 8192
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] din,
  input  logic       relock,
  output logic [9:0] dout,
  output logic       dout_ctrl,
  output logic [1:0] ctrl,
  output logic [3:0] offset,
  output logic       locked
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W = $clog2(LOSS_CYCLES);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(LOCK_COUNT);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(LOSS_CYCLES - 1);

  logic [9:0]       din_q;
  logic [9:0]       dout_q, dout_d;
  logic             dout_ctrl_q, dout_ctrl_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [3:0]       offset_q, offset_d;
  aligner_state_e   state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             skip_q, skip_d;

  logic [19:0]      window;
  logic [2:0]       token;
  logic             tok_valid;
  logic             timer_done;
  logic [3:0]       offset_next;
  logic [RUN_W-1:0] run_next;

  // Older word in the low half, so window[offset +: 10] is in serial order.
  always_comb begin
    window      = {din, din_q};
    dout_d      = window[{1'b0, offset_q} +: 10];
    token       = token_decode(dout_d);
    dout_ctrl_d = token[2];
    ctrl_d      = token[1:0];
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    run_d       = run_q;
    timer_d     = timer_q;
    skip_d      = 1'b0;

    // The word on dout just after an offset change was built at the old offset.
    tok_valid   = dout_ctrl_q & ~skip_q;
    timer_done  = (timer_q >= TMR_LAST);
    offset_next = (offset_q >= 4'd9) ? 4'd0 : offset_q + 4'd1;

    if (skip_q)                   run_next = run_q;
    else if (!dout_ctrl_q)        run_next = '0;
    else if (run_q >= RUN_TARGET) run_next = RUN_TARGET;
    else                          run_next = run_q + RUN_W'(1);

    if (relock) begin
      state_d  = SEARCH;
      offset_d = offset_next;
      run_d    = '0;
      timer_d  = '0;
      skip_d   = 1'b1;
    end else begin
      case (state_q)
        SEARCH: begin
          if (run_next >= RUN_TARGET) begin
            state_d = LOCKED;
            run_d   = '0;
            timer_d = '0;
          end else if (timer_done) begin
            offset_d = offset_next;
            run_d    = '0;
            timer_d  = '0;
            skip_d   = 1'b1;
          end else begin
            run_d   = run_next;
            timer_d = timer_q + TMR_W'(1);
          end
        end
        LOCKED: begin
          // Video words are arbitrary, so only token starvation drops lock.
          if (tok_valid) begin
            timer_d = '0;
          end else if (timer_done) begin
            state_d = SEARCH;
            run_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      din_q       <= '0;
      dout_q      <= '0;
      dout_ctrl_q <= 1'b0;
      ctrl_q      <= '0;
      offset_q    <= '0;
      state_q     <= SEARCH;
      run_q       <= '0;
      timer_q     <= '0;
      skip_q      <= 1'b0;
    end else begin
      din_q       <= din;
      dout_q      <= dout_d;
      dout_ctrl_q <= dout_ctrl_d;
      ctrl_q      <= ctrl_d;
      offset_q    <= offset_d;
      state_q     <= state_d;
      run_q       <= run_d;
      timer_q     <= timer_d;
      skip_q      <= skip_d;
    end
  end

  assign dout      = dout_q;
  assign dout_ctrl = dout_ctrl_q;
  assign ctrl      = ctrl_q;
  assign offset    = offset_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Randomized bench for tmds_word_aligner: a bit-stream generator feeds words at a
// chosen phase and a behavioural model predicts every output cycle by cycle.
module tb_tmds_word_aligner;

  localparam int LOCK_COUNT  = 8;
  localparam int LOSS_CYCLES = 64;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b1;
  logic [9:0] din       = '0;
  logic       relock    = 1'b0;
  logic [9:0] dout;
  logic       dout_ctrl;
  logic [1:0] ctrl;
  logic [3:0] offset;
  logic       locked;

  always #5 clk_pixel = ~clk_pixel;

  tmds_word_aligner #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_CYCLES(LOSS_CYCLES)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .din      (din),
    .relock   (relock),
    .dout     (dout),
    .dout_ctrl(dout_ctrl),
    .ctrl     (ctrl),
    .offset   (offset),
    .locked   (locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Token table indexed by {c1,c0}, written out independently of the design package.
  logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  function automatic int token_index(input logic [9:0] w);
    for (int i = 0; i < 4; i++)
      if (w == tokens[i]) return i;
    return -1;
  endfunction

  // Behavioural model state (plain integers).
  logic [9:0] m_prev_din;
  logic [9:0] m_dout;
  int         m_tok;       // token index of m_dout, -1 when not a token
  int         m_off;
  bit         m_locked;
  int         m_run;
  int         m_timer;
  bit         m_skip;
  logic [9:0] hist[$];
  logic [9:0] sym_prev = '0;

  function automatic void model_reset();
    m_prev_din = '0;
    m_dout     = '0;
    m_tok      = -1;
    m_off      = 0;
    m_locked   = 0;
    m_run      = 0;
    m_timer    = 0;
    m_skip     = 0;
  endfunction

  function automatic void model_edge(input logic [9:0] d, input logic rl);
    logic [19:0] w;
    bit          seen_tok;
    w        = {d, m_prev_din} >> m_off;
    seen_tok = (m_tok >= 0) && !m_skip;
    if (rl) begin
      m_off    = (m_off + 1) % 10;
      m_locked = 0;
      m_run    = 0;
      m_timer  = 0;
      m_skip   = 1;
    end else if (!m_locked) begin
      if (!m_skip) m_run = (m_tok >= 0) ? m_run + 1 : 0;
      m_skip = 0;
      if (m_run >= LOCK_COUNT) begin
        m_locked = 1;
        m_run    = 0;
        m_timer  = 0;
      end else if (m_timer == LOSS_CYCLES - 1) begin
        m_off   = (m_off + 1) % 10;
        m_run   = 0;
        m_timer = 0;
        m_skip  = 1;
      end else begin
        m_timer++;
      end
    end else begin
      m_skip = 0;
      if (seen_tok) m_timer = 0;
      else if (m_timer == LOSS_CYCLES - 1) begin
        m_locked = 0;
        m_run    = 0;
        m_timer  = 0;
      end else m_timer++;
    end
    m_prev_din = d;
    m_dout     = w[9:0];
    m_tok      = token_index(m_dout);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_dout"},      32'(dout),      32'(m_dout));
    check({tag, "_dout_ctrl"}, 32'(dout_ctrl), 32'(m_tok >= 0));
    check({tag, "_ctrl"},      32'(ctrl),      (m_tok >= 0) ? 32'(m_tok) : 32'd0);
    check({tag, "_offset"},    32'(offset),    32'(m_off));
    check({tag, "_locked"},    32'(locked),    32'(m_locked));
  endtask

  task automatic tick(input logic [9:0] d, input logic rl);
    din    = d;
    relock = rl;
    @(posedge clk_pixel);
    model_edge(d, rl);
    hist.push_back(d);
    #1;
    relock = 1'b0;
    compare_all("cyc");
  endtask

  // Serial symbol stream whose word boundary lands p bits into the deserializer word.
  task automatic send_sym(input logic [9:0] sym, input int p, input logic rl);
    logic [19:0] s;
    s        = {sym, sym_prev} >> (10 - p);
    sym_prev = sym;
    tick(s[9:0], rl);
  endtask

  function automatic logic [9:0] rand_video();
    logic [9:0] v;
    do v = 10'($urandom); while (token_index(v) >= 0);
    return v;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    din     = '0;
    relock  = 1'b0;
    #2;
    model_reset();
    compare_all("reset");
    repeat (2) @(posedge clk_pixel);
    #3;
    reset_n  = 1'b1;
    sym_prev = '0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    apply_reset();

    // Token stream at offset 3: search walks 0,1,2,3 then locks.
    for (int i = 0; i < 3 * LOSS_CYCLES + 30; i++) send_sym(tokens[0], 3, 1'b0);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_offset", 32'(offset), 32'd3);
    check("t1_dout",   32'(dout),   32'h354);
    check("t1_ctrl",   32'(ctrl),   32'd0);

    // Lock at offset 0, then a token and two data words pass straight through.
    apply_reset();
    for (int i = 0; i < 20; i++) send_sym(tokens[0], 0, 1'b0);
    check("t2_locked_pre", 32'(locked), 32'd1);
    send_sym(tokens[3], 0, 1'b0);
    check("t2_lat", 32'(dout), 32'(hist[hist.size()-2]));
    send_sym(10'h155, 0, 1'b0);
    check("t2_lat", 32'(dout), 32'(hist[hist.size()-2]));
    check("t2_tok_ctrl", 32'(ctrl), 32'd3);
    send_sym(10'h155, 0, 1'b0);
    check("t2_lat", 32'(dout), 32'(hist[hist.size()-2]));
    check("t2_data_ctrl", 32'(dout_ctrl), 32'd0);
    check("t2_locked_post", 32'(locked), 32'd1);

    // Token starvation drops lock without moving the offset.
    for (int i = 0; i < 70; i++) send_sym(rand_video(), 0, 1'b0);
    check("t3_locked", 32'(locked), 32'd0);
    check("t3_offset", 32'(offset), 32'd0);

    // Ten fruitless search periods wrap the offset, then tokens at offset 9 lock.
    apply_reset();
    for (int i = 0; i < 10 * LOSS_CYCLES; i++) send_sym(rand_video(), 9, 1'b0);
    check("t4_wrap_offset", 32'(offset), 32'd0);
    for (int i = 0; i < 9 * LOSS_CYCLES + 40; i++) send_sym(tokens[1], 9, 1'b0);
    check("t4_locked", 32'(locked), 32'd1);
    check("t4_offset", 32'(offset), 32'd9);

    // Manual bitslip while locked at offset 5.
    apply_reset();
    for (int i = 0; i < 5 * LOSS_CYCLES + 30; i++) send_sym(tokens[2], 5, 1'b0);
    check("t5_locked_pre", 32'(locked), 32'd1);
    send_sym(tokens[2], 5, 1'b1);
    check("t5_locked", 32'(locked), 32'd0);
    check("t5_offset", 32'(offset), 32'd6);
    for (int i = 0; i < 20; i++) send_sym(tokens[2], 5, 1'b0);

    // Asynchronous reset between edges while locked.
    apply_reset();
    for (int i = 0; i < 20; i++) send_sym(tokens[0], 0, 1'b0);
    check("t6_locked_pre", 32'(locked), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_dout",   32'(dout),      32'd0);
    check("t6_dctrl",  32'(dout_ctrl), 32'd0);
    check("t6_ctrl",   32'(ctrl),      32'd0);
    check("t6_offset", 32'(offset),    32'd0);
    check("t6_locked", 32'(locked),    32'd0);
    repeat (2) @(posedge clk_pixel);
    #3;
    reset_n  = 1'b1;
    sym_prev = '0;
    send_sym(rand_video(), 0, 1'b1);
    check("t6_relock_offset", 32'(offset), 32'd1);

    // Random phases, token densities and occasional relock pulses.
    for (int r = 0; r < 6; r++) begin
      int p;
      int dens;
      p    = $urandom_range(9);
      dens = $urandom_range(100, 60);
      for (int i = 0; i < 400; i++) begin
        logic [9:0] s;
        if ($urandom_range(99) < dens) s = tokens[$urandom_range(3)];
        else                           s = 10'($urandom);
        send_sym(s, p, ($urandom_range(299) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
